jk_counter_ctrl: RTL

//  Sequencer for a WIDTH-bit bank of JK flip-flops forming a synchronous counter.

---
 rtl/jk_counter_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/jk_counter_ctrl.sv
// Command sequencer for a WIDTH-bit JK flip-flop counter bank: clear, load, or
// count a programmed number of modulo-wrapping steps, then pulse done.
module jk_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MOD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LD, S_CNT, S_FIN} state_t;

  localparam logic [1:0]       OP_CLR = 2'b00;
  localparam logic [1:0]       OP_LD  = 2'b01;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MOD_MAX);

  state_t           state, state_nx;
  logic [WIDTH-1:0] steps, ld_val;
  logic             dir_dn;
  logic             accept;
  logic [WIDTH-1:0] set_v, clr_v, tog_v;
  logic [WIDTH-1:0] t_up, t_dn;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) state <= S_IDLE;
    else        state <= state_nx;
  end

  // done is registered so it lands on the first IDLE cycle after FIN
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      steps  <= '0;
      ld_val <= '0;
      dir_dn <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (accept) begin
        steps  <= cmd_data;
        ld_val <= cmd_data;
        dir_dn <= cmd_op[0];
      end else if (state == S_CNT) begin
        steps <= steps - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        if      (cmd_op == OP_CLR) state_nx = S_CLR;
        else if (cmd_op == OP_LD)  state_nx = S_LD;
        else if (cmd_data != '0)   state_nx = S_CNT;
        else                       state_nx = S_FIN;
      end
      S_CLR:   state_nx = S_FIN;
      S_LD:    state_nx = S_FIN;
      S_CNT:   if (steps == WIDTH'(1)) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // per-bit toggle enables: bit i flips when all lower bits are 1 (up) / 0 (down)
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      if (gi == 0) begin : g_lsb
        assign t_up[gi] = 1'b1;
        assign t_dn[gi] = 1'b1;
      end else begin : g_hi
        assign t_up[gi] = &q[gi-1:0];
        assign t_dn[gi] = ~|q[gi-1:0];
      end
      assign j[gi] = set_v[gi] | tog_v[gi];
      assign k[gi] = clr_v[gi] | tog_v[gi];
    end
  endgenerate

  always_comb begin
    set_v     = '0;
    clr_v     = '0;
    tog_v     = '0;
    wrap      = 1'b0;
    busy      = (state != S_IDLE);
    cmd_ready = (state == S_IDLE);
    case (state)
      S_CLR: clr_v = '1;
      S_LD: begin
        set_v = ld_val;
        clr_v = ~ld_val;
      end
      S_CNT: begin
        if (!dir_dn) begin
          // anything at or above MOD_MAX (including out-of-range loads) wraps to 0
          if (q >= MAXV) begin
            clr_v = q;
            wrap  = 1'b1;
          end else begin
            tog_v = t_up;
          end
        end else if (q == '0) begin
          set_v = MAXV;
          wrap  = 1'b1;
        end else begin
          tog_v = t_dn;
        end
      end
      default: ;
    endcase
  end

endmodule
